wb_mem_stage: RTL and testbench
===============================

// Module: wb_mem_stage
// PURPOSE
//  Memory/writeback stage that sits directly upstream of reg_file and drives its write port.
//  - ALU results: registered and written back at one op per cycle.
//  - Loads and stores: go through a req/ack data-memory handshake.
//  - Load data: always lands in the dedicated register through the MemtoReg path.
//  - A bounded ack wait (timeout) stops a dead memory from hanging the core.
// PARAMETERS
//  DW       8   data width (reg file and memory)
//  AW       8   memory address width; address = in_alu_res[AW-1:0]
//  RW       3   register address width
//  DED_REG  2   dedicated load-destination register index
//  TIMEOUT  15  max cycles mem_req is held without mem_ack; range 1..255
// PORTS
//  clk           in   1   clock, all state on posedge
//  reset         in   1   synchronous, active-high
//  in_valid      in   1   upstream op valid
//  in_ready      out  1   stage can accept; = (state==IDLE) && !reset
//  in_is_load    in   1   op is a load
//  in_is_store   in   1   op is a store
//  in_wr_en      in   1   ALU op writes a register
//  in_wr_addr    in   RW  ALU destination register
//  in_alu_res    in   DW  ALU result, or memory address for load/store
//  in_store_dat  in   DW  store data
//  mem_req       out  1   memory request, registered
//  mem_we        out  1   1 = write, 0 = read
//  mem_addr      out  AW  memory address
//  mem_wdat      out  DW  memory write data
//  mem_ack       in   1   memory completes; sampled only while mem_req=1
//  mem_rdat      in   DW  read data, valid with mem_ack
//  rf_dat        out  DW  to reg_file dat_in
//  rf_wr_en      out  1   to reg_file wr_en
//  rf_MemtoReg   out  1   to reg_file MemtoReg (load write to DED_REG)
//  rf_wr_addr    out  RW  to reg_file wr_addr
//  err           out  1   sticky: timeout or illegal op; cleared only by reset
// BEHAVIOUR
//  Reset: every output is 0, including in_ready; state = IDLE; timeout count = 0.
//  Reset mid-transaction abandons it: mem_req and rf_* are 0 in the cycle after the reset edge; no writeback occurs.
//  States: IDLE, MEM.
//  An op is accepted at a posedge where in_valid && in_ready. Call that edge T.
//  IDLE, ALU op (neither load nor store):
//   - In the cycle after T: rf_wr_en=in_wr_en, rf_wr_addr=in_wr_addr, rf_dat=in_alu_res.
//   - rf_wr_en is high for exactly 1 cycle; stay in IDLE, so back-to-back ALU ops run at 1/cycle.
//   - rf_wr_en is forced 0 when in_wr_addr is 0 or 1; those registers are constants.
//  IDLE, load or store:
//   - Go to MEM. In the cycle after T: mem_req=1, mem_addr=in_alu_res[AW-1:0].
//   - mem_we=in_is_store; mem_wdat=in_store_dat for a store, else 0.
//  MEM: mem_req, mem_we, mem_addr and mem_wdat are held stable until the ack edge or the timeout.
//  Ack edge, i.e. the posedge where mem_ack=1 (ack in the first MEM cycle is legal):
//   - mem_req=0 and return to IDLE.
//   - Load: in the next cycle, rf_MemtoReg=1, rf_wr_addr=DED_REG, rf_dat=captured mem_rdat, for 1 cycle.
//   - Store: no writeback.
//   - Minimum load latency: accept edge to rf_MemtoReg is 2 cycles.
//  Timeout:
//   - An 8-bit counter counts MEM cycles without ack.
//   - At the TIMEOUT-th such posedge: mem_req=0, err=1, return to IDLE, no writeback.
//   - An ack on that same edge wins: normal completion, no err.
//  Illegal op: in_is_load && in_is_store → executed as a store; err=1.
//  rf_wr_en and rf_MemtoReg are never high in the same cycle.
//  mem_ack while mem_req=0 is ignored.
// CONFIGURATION
//  WB_FWD_EN defined adds outputs fwd_valid(1), fwd_addr(RW), fwd_dat(DW):
//   - fwd_valid = rf_wr_en | rf_MemtoReg.
//   - fwd_addr = the effective destination (DED_REG on a load).
//   - fwd_dat = rf_dat.
//   - Used by decode for bypass; all three are 0 on reset.
//  WB_FWD_EN undefined: the three ports do not exist; all other behaviour is identical.
// TESTING
//  1. Reset 2 cycles, then release → all outputs 0 during reset; in_ready=1 in the first cycle after release.
//  2. ALU ops wr_addr=3 res=0x5A, then wr_addr=4 res=0xA5 on consecutive cycles
//     → rf_wr_en high 2 cycles with matching addr/dat; wr_addr=1 → rf_wr_en stays 0.
//  3. Load addr=0x10, mem_ack on the 3rd req cycle with rdat=0x7E
//     → in_ready=0 while waiting; one cycle later rf_MemtoReg=1, rf_wr_addr=2, rf_dat=0x7E.
//  4. Store addr=0xFF dat=0x33, ack in the first req cycle
//     → mem_we=1, mem_addr=0xFF, mem_wdat=0x33; no rf write; in_ready=1 the next cycle.
//  5. Load with no ack, TIMEOUT=15 → mem_req high exactly 15 cycles, then err=1, no rf write;
//     repeat with ack on the 15th edge → no err. Also assert in_is_load && in_is_store
//     → executed as a store and err=1.
//  6. Reset asserted while in MEM → mem_req=0 the next cycle, no writeback.
//     With WB_FWD_EN defined, re-run 2-3 → fwd_* mirror the rf writes exactly.

Source files
------------

// File: rtl/wb_mem_stage_if.sv
// Bundle of upstream op, data-memory and reg_file write-port signals for wb_mem_stage.
// Forwarding outputs exist only when WB_FWD_EN is defined.
interface wb_mem_stage_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8,
    parameter int unsigned RW = 3
);
    logic          in_valid;
    logic          in_ready;
    logic          in_is_load;
    logic          in_is_store;
    logic          in_wr_en;
    logic [RW-1:0] in_wr_addr;
    logic [DW-1:0] in_alu_res;
    logic [DW-1:0] in_store_dat;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdat;
    logic          mem_ack;
    logic [DW-1:0] mem_rdat;

    logic [DW-1:0] rf_dat;
    logic          rf_wr_en;
    logic          rf_MemtoReg;
    logic [RW-1:0] rf_wr_addr;
    logic          err;
`ifdef WB_FWD_EN
    logic          fwd_valid;
    logic [RW-1:0] fwd_addr;
    logic [DW-1:0] fwd_dat;
`endif

    // Stage side
    modport slave (
        input  in_valid, in_is_load, in_is_store, in_wr_en, in_wr_addr, in_alu_res, in_store_dat,
        input  mem_ack, mem_rdat,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdat,
`ifdef WB_FWD_EN
        output fwd_valid, fwd_addr, fwd_dat,
`endif
        output rf_dat, rf_wr_en, rf_MemtoReg, rf_wr_addr, err
    );

    // Upstream/memory/reg_file side
    modport master (
        output in_valid, in_is_load, in_is_store, in_wr_en, in_wr_addr, in_alu_res, in_store_dat,
        output mem_ack, mem_rdat,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdat,
`ifdef WB_FWD_EN
        input  fwd_valid, fwd_addr, fwd_dat,
`endif
        input  rf_dat, rf_wr_en, rf_MemtoReg, rf_wr_addr, err
    );
endinterface

// File: rtl/wb_mem_stage.sv
// Memory/writeback stage: ALU results written back at 1/cycle, loads/stores via req/ack with
// a bounded ack wait. Optional bypass outputs are enabled with WB_FWD_EN.
module wb_mem_stage #(
    parameter int unsigned DW      = 8,
    parameter int unsigned AW      = 8,
    parameter int unsigned RW      = 3,
    parameter int unsigned DED_REG = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            reset,
    wb_mem_stage_if.slave   bus
);
    localparam int unsigned CW = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MEM  = 1'b1
    } state_t;

    state_t        r_state,       w_state_nxt;
    logic          r_mem_req,     w_mem_req_nxt;
    logic          r_mem_we,      w_mem_we_nxt;
    logic [AW-1:0] r_mem_addr,    w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdat,    w_mem_wdat_nxt;
    logic [DW-1:0] r_rf_dat,      w_rf_dat_nxt;
    logic          r_rf_wr_en,    w_rf_wr_en_nxt;
    logic          r_rf_m2r,      w_rf_m2r_nxt;
    logic [RW-1:0] r_rf_wr_addr,  w_rf_wr_addr_nxt;
    logic          r_err,         w_err_nxt;
    logic [CW-1:0] r_cnt,         w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdat   <= '0;
            r_rf_dat     <= '0;
            r_rf_wr_en   <= 1'b0;
            r_rf_m2r     <= 1'b0;
            r_rf_wr_addr <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdat   <= w_mem_wdat_nxt;
            r_rf_dat     <= w_rf_dat_nxt;
            r_rf_wr_en   <= w_rf_wr_en_nxt;
            r_rf_m2r     <= w_rf_m2r_nxt;
            r_rf_wr_addr <= w_rf_wr_addr_nxt;
            r_err        <= w_err_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    // Next-state and output logic; write strobes are single-cycle pulses
    always_comb begin
        w_state_nxt      = r_state;
        w_mem_req_nxt    = r_mem_req;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdat_nxt   = r_mem_wdat;
        w_rf_dat_nxt     = r_rf_dat;
        w_rf_wr_en_nxt   = 1'b0;
        w_rf_m2r_nxt     = 1'b0;
        w_rf_wr_addr_nxt = r_rf_wr_addr;
        w_err_nxt        = r_err;
        w_cnt_nxt        = r_cnt;
        w_cnt_inc        = r_cnt + CW'(1);

        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.in_is_load || bus.in_is_store) begin
                        w_state_nxt    = S_MEM;
                        w_mem_req_nxt  = 1'b1;
                        w_mem_we_nxt   = bus.in_is_store;
                        w_mem_addr_nxt = bus.in_alu_res[AW-1:0];
                        w_mem_wdat_nxt = bus.in_is_store ? bus.in_store_dat : '0;
                        w_cnt_nxt      = '0;
                        // Load+store together runs as a store but is flagged
                        if (bus.in_is_load && bus.in_is_store) begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        // Registers 0 and 1 are constants and never written
                        w_rf_wr_en_nxt   = bus.in_wr_en && (bus.in_wr_addr > RW'(1));
                        w_rf_wr_addr_nxt = bus.in_wr_addr;
                        w_rf_dat_nxt     = bus.in_alu_res;
                    end
                end
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    w_state_nxt    = S_IDLE;
                    w_mem_req_nxt  = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = '0;
                    w_mem_wdat_nxt = '0;
                    w_cnt_nxt      = '0;
                    if (!r_mem_we) begin
                        w_rf_m2r_nxt     = 1'b1;
                        w_rf_wr_addr_nxt = RW'(DED_REG);
                        w_rf_dat_nxt     = bus.mem_rdat;
                    end
                end else if (w_cnt_inc == CW'(TIMEOUT)) begin
                    // Dead memory: abandon the access, no writeback
                    w_state_nxt    = S_IDLE;
                    w_mem_req_nxt  = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                    w_mem_addr_nxt = '0;
                    w_mem_wdat_nxt = '0;
                    w_cnt_nxt      = '0;
                    w_err_nxt      = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready    = (r_state == S_IDLE) && !reset;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_wdat    = r_mem_wdat;
    assign bus.rf_dat      = r_rf_dat;
    assign bus.rf_wr_en    = r_rf_wr_en;
    assign bus.rf_MemtoReg = r_rf_m2r;
    assign bus.rf_wr_addr  = r_rf_wr_addr;
    assign bus.err         = r_err;

`ifdef WB_FWD_EN
    // Bypass view of the write port for decode
    assign bus.fwd_valid = r_rf_wr_en | r_rf_m2r;
    assign bus.fwd_addr  = r_rf_wr_addr;
    assign bus.fwd_dat   = r_rf_dat;
`endif

endmodule

// File: tb/tb_wb_mem_stage.sv
// Bench for wb_mem_stage: ALU vector table, directed memory/timeout/reset sequences and
// randomized ops checked against a transaction-level model with a memory array.
module tb_wb_mem_stage;
    localparam int unsigned DW      = 8;
    localparam int unsigned AW      = 8;
    localparam int unsigned RW      = 3;
    localparam int unsigned DED_REG = 2;
    localparam int          TMO     = 15;

    logic clk;
    logic reset;

    wb_mem_stage_if #(.DW(DW), .AW(AW), .RW(RW)) bus ();

    wb_mem_stage #(.DW(DW), .AW(AW), .RW(RW), .DED_REG(DED_REG), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic err_exp;
    logic [7:0] resp_mem  [256];
    logic [7:0] model_mem [256];

    typedef struct {
        logic       wr_en;
        logic [2:0] wr_addr;
        logic [7:0] res;
        logic       exp_en;
        logic [2:0] exp_addr;
        logic [7:0] exp_dat;
    } alu_vec_t;

    alu_vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string nm, input logic en, input logic m2r,
                          input logic [2:0] a, input logic [7:0] d);
        chk({nm, "_wr_en"}, 32'(bus.rf_wr_en), 32'(en));
        chk({nm, "_m2r"}, 32'(bus.rf_MemtoReg), 32'(m2r));
        if (en || m2r) begin
            chk({nm, "_addr"}, 32'(bus.rf_wr_addr), 32'(a));
            chk({nm, "_dat"}, 32'(bus.rf_dat), 32'(d));
        end
`ifdef WB_FWD_EN
        chk({nm, "_fwd_valid"}, 32'(bus.fwd_valid), 32'(en | m2r));
        if (en || m2r) begin
            chk({nm, "_fwd_addr"}, 32'(bus.fwd_addr), 32'(a));
            chk({nm, "_fwd_dat"}, 32'(bus.fwd_dat), 32'(d));
        end
`endif
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, 32'(bus.in_ready), 0);
        chk({nm, "_req"}, 32'(bus.mem_req), 0);
        chk({nm, "_we"}, 32'(bus.mem_we), 0);
        chk({nm, "_maddr"}, 32'(bus.mem_addr), 0);
        chk({nm, "_wdat"}, 32'(bus.mem_wdat), 0);
        chk({nm, "_rfdat"}, 32'(bus.rf_dat), 0);
        chk({nm, "_rfen"}, 32'(bus.rf_wr_en), 0);
        chk({nm, "_m2r"}, 32'(bus.rf_MemtoReg), 0);
        chk({nm, "_rfaddr"}, 32'(bus.rf_wr_addr), 0);
        chk({nm, "_err"}, 32'(bus.err), 0);
`ifdef WB_FWD_EN
        chk({nm, "_fwdv"}, 32'(bus.fwd_valid), 0);
        chk({nm, "_fwda"}, 32'(bus.fwd_addr), 0);
        chk({nm, "_fwdd"}, 32'(bus.fwd_dat), 0);
`endif
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            chk_all_zero("reset");
        end
        reset = 1'b0;
        err_exp = 1'b0;
        #1;
        chk("ready_after_reset", 32'(bus.in_ready), 1);
    endtask

    // Issue one op; d = non-ack edges before the ack edge (d >= TMO means memory never acks)
    task automatic do_op(input logic ld, input logic st, input logic we, input logic [2:0] wa,
                         input logic [7:0] res, input logic [7:0] sd, input int d);
        logic exp_en;
        logic ack;
        logic done;
        chk("ready_before_op", 32'(bus.in_ready), 1);
        bus.in_valid     = 1'b1;
        bus.in_is_load   = ld;
        bus.in_is_store  = st;
        bus.in_wr_en     = we;
        bus.in_wr_addr   = wa;
        bus.in_alu_res   = res;
        bus.in_store_dat = sd;
        bus.mem_ack      = 1'($urandom_range(0, 1));
        bus.mem_rdat     = 8'($urandom);
        step();
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        if (!ld && !st) begin
            exp_en = we && (wa > 3'd1);
            chk_wb("alu", exp_en, 1'b0, wa, res);
            chk("alu_req", 32'(bus.mem_req), 0);
            chk("alu_ready", 32'(bus.in_ready), 1);
            chk("alu_err", 32'(bus.err), 32'(err_exp));
        end else begin
            if (ld && st) err_exp = 1'b1;
            chk("req_start", 32'(bus.mem_req), 1);
            chk("we_start", 32'(bus.mem_we), 32'(st));
            chk("maddr_start", 32'(bus.mem_addr), 32'(res));
            chk("wdat_start", 32'(bus.mem_wdat), st ? 32'(sd) : 0);
            chk("ready_start", 32'(bus.in_ready), 0);
            chk_wb("mem_start", 1'b0, 1'b0, 3'd0, 8'd0);
            chk("err_start", 32'(bus.err), 32'(err_exp));
            done = 1'b0;
            for (int k = 1; k <= TMO; k++) begin
                if (!done) begin
                    ack = (k == d + 1);
                    bus.mem_ack  = ack;
                    bus.mem_rdat = (ack && !bus.mem_we) ? resp_mem[bus.mem_addr] : 8'($urandom);
                    if (ack && bus.mem_we) resp_mem[bus.mem_addr] = bus.mem_wdat;
                    step();
                    bus.mem_ack = 1'b0;
                    if (ack) begin
                        done = 1'b1;
                        chk("req_after_ack", 32'(bus.mem_req), 0);
                        chk_wb("ack", 1'b0, !st, 3'(DED_REG), model_mem[res]);
                        if (st) model_mem[res] = sd;
                        chk("ready_after_ack", 32'(bus.in_ready), 1);
                        chk("err_after_ack", 32'(bus.err), 32'(err_exp));
                    end else if (k == TMO) begin
                        done = 1'b1;
                        err_exp = 1'b1;
                        chk("req_after_tmo", 32'(bus.mem_req), 0);
                        chk_wb("tmo", 1'b0, 1'b0, 3'd0, 8'd0);
                        chk("ready_after_tmo", 32'(bus.in_ready), 1);
                        chk("err_after_tmo", 32'(bus.err), 1);
                    end else begin
                        chk("req_hold", 32'(bus.mem_req), 1);
                        chk("maddr_hold", 32'(bus.mem_addr), 32'(res));
                        chk("we_hold", 32'(bus.mem_we), 32'(st));
                        chk("ready_wait", 32'(bus.in_ready), 0);
                        chk_wb("wait", 1'b0, 1'b0, 3'd0, 8'd0);
                    end
                end
            end
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 3'd3, 8'h5A, 1'b1, 3'd3, 8'h5A};
        vecs[1] = '{1'b1, 3'd4, 8'hA5, 1'b1, 3'd4, 8'hA5};
        vecs[2] = '{1'b1, 3'd1, 8'h77, 1'b0, 3'd1, 8'h77};
        vecs[3] = '{1'b1, 3'd0, 8'h12, 1'b0, 3'd0, 8'h12};
        vecs[4] = '{1'b0, 3'd5, 8'h34, 1'b0, 3'd5, 8'h34};
        vecs[5] = '{1'b1, 3'd7, 8'hFF, 1'b1, 3'd7, 8'hFF};
        vecs[6] = '{1'b1, 3'd2, 8'h00, 1'b1, 3'd2, 8'h00};

        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'($urandom);
            resp_mem[i]  = v;
            model_mem[i] = v;
        end
        resp_mem[8'h10]  = 8'h7E;
        model_mem[8'h10] = 8'h7E;

        reset            = 1'b1;
        err_exp          = 1'b0;
        bus.in_valid     = 1'b0;
        bus.in_is_load   = 1'b0;
        bus.in_is_store  = 1'b0;
        bus.in_wr_en     = 1'b0;
        bus.in_wr_addr   = '0;
        bus.in_alu_res   = '0;
        bus.in_store_dat = '0;
        bus.mem_ack      = 1'b0;
        bus.mem_rdat     = '0;
        do_reset(2);

        // Back-to-back ALU ops from the vector table
        for (int i = 0; i < 7; i++) begin
            bus.in_valid    = 1'b1;
            bus.in_is_load  = 1'b0;
            bus.in_is_store = 1'b0;
            bus.in_wr_en    = vecs[i].wr_en;
            bus.in_wr_addr  = vecs[i].wr_addr;
            bus.in_alu_res  = vecs[i].res;
            step();
            chk_wb("vec", vecs[i].exp_en, 1'b0, vecs[i].exp_addr, vecs[i].exp_dat);
            chk("vec_ready", 32'(bus.in_ready), 1);
        end
        bus.in_valid = 1'b0;
        step();
        chk_wb("vec_idle", 1'b0, 1'b0, 3'd0, 8'd0);

        // Load with ack on the 3rd request cycle, then store acked immediately
        do_op(1'b1, 1'b0, 1'b0, 3'd0, 8'h10, 8'h00, 2);
        do_op(1'b0, 1'b1, 1'b0, 3'd0, 8'hFF, 8'h33, 0);
        do_op(1'b1, 1'b0, 1'b0, 3'd0, 8'hFF, 8'h00, 0);

        // Ack on the timeout edge wins; then a dead memory times out
        do_op(1'b1, 1'b0, 1'b0, 3'd0, 8'h21, 8'h00, TMO - 1);
        chk("no_err_ack_on_tmo_edge", 32'(bus.err), 0);
        do_op(1'b1, 1'b0, 1'b0, 3'd0, 8'h22, 8'h00, TMO);
        step();
        chk_wb("after_tmo", 1'b0, 1'b0, 3'd0, 8'd0);
        chk("err_sticky", 32'(bus.err), 1);
        do_reset(1);

        // Illegal load+store runs as a store and flags err
        do_op(1'b1, 1'b1, 1'b0, 3'd0, 8'h30, 8'h9C, 1);
        chk("illegal_err", 32'(bus.err), 1);
        do_op(1'b1, 1'b0, 1'b0, 3'd0, 8'h30, 8'h00, 0);
        do_reset(2);

        // Reset while a load is waiting for ack
        bus.in_valid    = 1'b1;
        bus.in_is_load  = 1'b1;
        bus.in_is_store = 1'b0;
        bus.in_alu_res  = 8'h20;
        step();
        bus.in_valid   = 1'b0;
        bus.in_is_load = 1'b0;
        step();
        step();
        chk("rst_mem_req_before", 32'(bus.mem_req), 1);
        reset        = 1'b1;
        bus.mem_ack  = 1'b1;
        bus.mem_rdat = 8'hC3;
        step();
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk_wb("rst_mem", 1'b0, 1'b0, 3'd0, 8'd0);
        reset       = 1'b0;
        bus.mem_ack = 1'b0;
        step();
        chk("rst_mem_req2", 32'(bus.mem_req), 0);
        chk_wb("rst_mem2", 1'b0, 1'b0, 3'd0, 8'd0);
        chk("rst_mem_ready", 32'(bus.in_ready), 1);
        chk("rst_mem_err", 32'(bus.err), 0);
        err_exp = 1'b0;

        // Randomized op stream against the model
        for (int n = 0; n < 150; n++) begin
            int kind;
            int dly;
            logic ld;
            logic st;
            kind = int'($urandom_range(0, 19));
            ld = (kind >= 10 && kind < 14) || kind == 19;
            st = (kind >= 14);
            dly = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) dly = TMO - 1 + int'($urandom_range(0, 1));
            if (ld || st)
                do_op(ld, st, 1'b0, 3'd0, 8'($urandom_range(0, 15)), 8'($urandom), dly);
            else
                do_op(1'b0, 1'b0, 1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
